// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: request/response/memory bundle for the instruction memory
// arbiter.
//   slave  : the arbiter side. It takes requests and mem_data_out, and drives
//            the readies, the responses and the memory address/data/write.
//   master : the requester/memory side (fetch unit, debug bridge, imemory).
interface imem_arbiter_if;
    logic        fetch_req_valid;
    logic        fetch_req_ready;
    logic [31:0] fetch_req_addr;
    logic        fetch_rsp_valid;
    logic [31:0] fetch_rsp_data;
    logic        fetch_rsp_err;

    logic        dbg_req_valid;
    logic        dbg_req_ready;
    logic        dbg_req_write;
    logic [31:0] dbg_req_addr;
    logic [31:0] dbg_req_wdata;
    logic        dbg_rsp_valid;
    logic [31:0] dbg_rsp_data;
    logic        dbg_rsp_err;

    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_read_write;
    logic [31:0] mem_data_out;

    modport slave (
        input  fetch_req_valid, fetch_req_addr,
        input  dbg_req_valid, dbg_req_write, dbg_req_addr, dbg_req_wdata,
        input  mem_data_out,
        output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
        output dbg_req_ready, dbg_rsp_valid, dbg_rsp_data, dbg_rsp_err,
        output mem_address, mem_data_in, mem_read_write
    );

    modport master (
        output fetch_req_valid, fetch_req_addr,
        output dbg_req_valid, dbg_req_write, dbg_req_addr, dbg_req_wdata,
        output mem_data_out,
        input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
        input  dbg_req_ready, dbg_rsp_valid, dbg_rsp_data, dbg_rsp_err,
        input  mem_address, mem_data_in, mem_read_write
    );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: single-port instruction memory access controller shared by the
// CPU fetch stage and the debug/program-load port.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   bus (slave)    : fetch and debug request/response channels, plus the
//                    combinational memory drive (address, write data, write
//                    enable) and the memory read data
// Debug has priority. Fetch is forced after MAX_DEBUG_RUN back-to-back debug
// grants while it waits. Responses are registered and arrive one cycle after
// the grant.
// Optional macro IMEM_ARB_RANGE_CHECK_EN flags misaligned or out-of-window
// addresses as errors. An errored request gets no memory write and returns
// data 0.
module imem_arbiter #(
    parameter logic [31:0] START_ADDR    = 32'h0100_0000,
    parameter int          MEM_DEPTH     = 65536,
    parameter int          MAX_DEBUG_RUN = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    imem_arbiter_if.slave   bus
);
    if (MAX_DEBUG_RUN < 1 || MAX_DEBUG_RUN > 15) begin : g_bad_run
        $error("imem_arbiter: MAX_DEBUG_RUN must be 1..15");
    end
    if (MEM_DEPTH < 8 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("imem_arbiter: MEM_DEPTH must be a power of two >= 8");
    end
    if (START_ADDR[1:0] != 2'b00) begin : g_bad_base
        $error("imem_arbiter: START_ADDR must be word aligned");
    end

    typedef enum logic { DBG_PRI, FETCH_FORCE } state_t;

    localparam logic [3:0] RUN_LAST = 4'(MAX_DEBUG_RUN - 1);

    state_t      state;
    logic [3:0]  run_cnt;
    logic        fetch_gnt, dbg_gnt;
    logic        fetch_err, dbg_err;

    logic        fetch_rsp_valid, dbg_rsp_valid;
    logic        fetch_rsp_err, dbg_rsp_err;
    logic [31:0] fetch_rsp_data, dbg_rsp_data;

`ifdef IMEM_ARB_RANGE_CHECK_EN
    // 33-bit compare so a window touching the top of the address space does
    // not wrap.
    localparam logic [32:0] WIN_LO = {1'b0, START_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + 33'(MEM_DEPTH);

    function automatic logic addr_bad(input logic [31:0] a);
        return ({1'b0, a} < WIN_LO) || ({1'b0, a} >= WIN_HI) || (a[1:0] != 2'b00);
    endfunction

    assign fetch_err = addr_bad(bus.fetch_req_addr);
    assign dbg_err   = addr_bad(bus.dbg_req_addr);
`else
    assign fetch_err = 1'b0;
    assign dbg_err   = 1'b0;
`endif

    // Grant for the current cycle. Gating by reset_n keeps the readies and the
    // memory write enable at their reset values while reset is asserted.
    always_comb begin
        fetch_gnt = 1'b0;
        dbg_gnt   = 1'b0;
        if (reset_n) begin
            if (state == DBG_PRI) begin
                if (bus.dbg_req_valid)        dbg_gnt   = 1'b1;
                else if (bus.fetch_req_valid) fetch_gnt = 1'b1;
            end else begin
                fetch_gnt = bus.fetch_req_valid;
            end
        end
    end

    assign bus.fetch_req_ready = fetch_gnt;
    assign bus.dbg_req_ready   = dbg_gnt;

    // When idle the fetch address is presented, so the bus is never left
    // floating.
    assign bus.mem_address    = dbg_gnt ? bus.dbg_req_addr : bus.fetch_req_addr;
    assign bus.mem_data_in    = dbg_gnt ? bus.dbg_req_wdata : 32'h0;
    assign bus.mem_read_write = dbg_gnt & bus.dbg_req_write & ~dbg_err;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= DBG_PRI;
            run_cnt         <= 4'd0;
            fetch_rsp_valid <= 1'b0;
            fetch_rsp_err   <= 1'b0;
            fetch_rsp_data  <= 32'h0;
            dbg_rsp_valid   <= 1'b0;
            dbg_rsp_err     <= 1'b0;
            dbg_rsp_data    <= 32'h0;
        end else begin
            fetch_rsp_valid <= fetch_gnt;
            fetch_rsp_err   <= fetch_gnt & fetch_err;
            dbg_rsp_valid   <= dbg_gnt;
            dbg_rsp_err     <= dbg_gnt & dbg_err;
            if (fetch_gnt)
                fetch_rsp_data <= fetch_err ? 32'h0 : bus.mem_data_out;
            if (dbg_gnt)
                dbg_rsp_data <= (dbg_err || bus.dbg_req_write) ? 32'h0 : bus.mem_data_out;

            case (state)
                DBG_PRI: begin
                    // The run length is counted only while fetch is waiting.
                    // A fetch grant or an idle fetch starts the count over.
                    if (dbg_gnt && bus.fetch_req_valid) begin
                        run_cnt <= run_cnt + 4'd1;
                        if (run_cnt == RUN_LAST) state <= FETCH_FORCE;
                    end else begin
                        run_cnt <= 4'd0;
                    end
                end
                FETCH_FORCE: begin
                    state   <= DBG_PRI;
                    run_cnt <= 4'd0;
                end
                default: begin
                    state   <= DBG_PRI;
                    run_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign bus.fetch_rsp_valid = fetch_rsp_valid;
    assign bus.fetch_rsp_err   = fetch_rsp_err;
    assign bus.fetch_rsp_data  = fetch_rsp_data;
    assign bus.dbg_rsp_valid   = dbg_rsp_valid;
    assign bus.dbg_rsp_err     = dbg_rsp_err;
    assign bus.dbg_rsp_data    = dbg_rsp_data;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed bench for imem_arbiter with a small word-array
// model of imemory (combinational read, write on the rising edge).
// Inputs change 1 ns after the rising edge. Combinational outputs are checked
// 1 ns after that, and registered responses 1 ns after the next rising edge.
module tb_imem_arbiter;
    logic clock;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    imem_arbiter_if bus();

    imem_arbiter #(
        .START_ADDR   (32'h0100_0000),
        .MEM_DEPTH    (65536),
        .MAX_DEBUG_RUN(4)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // imemory model: the word index is the truncated byte address.
    logic [31:0] mem [0:16383];
    initial for (int i = 0; i < 16384; i++) mem[i] = 32'hA000_0000 + i;
    always @(posedge clock) if (bus.mem_read_write) mem[bus.mem_address[15:2]] <= bus.mem_data_in;
    assign bus.mem_data_out = mem[bus.mem_address[15:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [9:0] pat;

        reset_n             = 1'b0;
        bus.fetch_req_valid = 1'b1;
        bus.fetch_req_addr  = 32'h0100_0000;
        bus.dbg_req_valid   = 1'b1;
        bus.dbg_req_write   = 1'b1;
        bus.dbg_req_addr    = 32'h0100_0000;
        bus.dbg_req_wdata   = 32'h1111_1111;
        #12;
        // Reset state. Requests are valid but must not be granted or written.
        chk("rst_fetch_rsp_valid", 32'(bus.fetch_rsp_valid), 32'd0);
        chk("rst_dbg_rsp_valid",   32'(bus.dbg_rsp_valid),   32'd0);
        chk("rst_fetch_rsp_data",  bus.fetch_rsp_data,       32'h0);
        chk("rst_dbg_rsp_data",    bus.dbg_rsp_data,         32'h0);
        chk("rst_rsp_err",         32'({bus.fetch_rsp_err, bus.dbg_rsp_err}), 32'd0);
        chk("rst_mem_read_write",  32'(bus.mem_read_write),  32'd0);
        chk("rst_readies",         32'({bus.fetch_req_ready, bus.dbg_req_ready}), 32'd0);
        bus.fetch_req_valid = 1'b0;
        bus.dbg_req_valid   = 1'b0;
        bus.dbg_req_write   = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Fetch only: four sequential words, one per cycle.
        bus.fetch_req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.fetch_req_addr = 32'h0100_0000 + 32'(4 * i);
            #1;
            chk("fo_ready", 32'(bus.fetch_req_ready), 32'd1);
            chk("fo_addr",  bus.mem_address, 32'h0100_0000 + 32'(4 * i));
            tick();
            chk("fo_rsp_valid", 32'(bus.fetch_rsp_valid), 32'd1);
            chk("fo_rsp_data",  bus.fetch_rsp_data, 32'hA000_0000 + 32'(i));
        end
        bus.fetch_req_valid = 1'b0;
        #1;
        chk("fo_idle_ready", 32'(bus.fetch_req_ready), 32'd0);
        tick();
        chk("fo_idle_rsp", 32'(bus.fetch_rsp_valid), 32'd0);

        // Debug write followed by read-back of the same word.
        bus.dbg_req_valid = 1'b1;
        bus.dbg_req_write = 1'b1;
        bus.dbg_req_addr  = 32'h0100_0010;
        bus.dbg_req_wdata = 32'hDEAD_BEEF;
        #1;
        chk("dw_ready",   32'(bus.dbg_req_ready), 32'd1);
        chk("dw_we",      32'(bus.mem_read_write), 32'd1);
        chk("dw_wdata",   bus.mem_data_in, 32'hDEAD_BEEF);
        chk("dw_addr",    bus.mem_address, 32'h0100_0010);
        tick();
        chk("dw_rsp_valid", 32'(bus.dbg_rsp_valid), 32'd1);
        chk("dw_rsp_data",  bus.dbg_rsp_data, 32'h0);
        bus.dbg_req_write = 1'b0;
        #1;
        chk("dr_we", 32'(bus.mem_read_write), 32'd0);
        tick();
        chk("dr_rsp_valid", 32'(bus.dbg_rsp_valid), 32'd1);
        chk("dr_rsp_data",  bus.dbg_rsp_data, 32'hDEAD_BEEF);
        chk("dr_no_fetch",  32'(bus.fetch_rsp_valid), 32'd0);

        // Both valid continuously: D,D,D,D,F repeating (bit i = fetch wins).
        bus.fetch_req_valid = 1'b1;
        bus.fetch_req_addr  = 32'h0100_0004;
        pat = 10'b10000_10000;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("arb_fetch_ready", 32'(bus.fetch_req_ready), 32'(pat[i]));
            chk("arb_dbg_ready",   32'(bus.dbg_req_ready),   32'(!pat[i]));
            tick();
            chk("arb_fetch_rsp", 32'(bus.fetch_rsp_valid), 32'(pat[i]));
            if (pat[i]) chk("arb_fetch_data", bus.fetch_rsp_data, 32'hA000_0001);
            else        chk("arb_dbg_data",   bus.dbg_rsp_data,   32'hDEAD_BEEF);
        end

        // Fetch idle, debug continuous: no forced fetch slot, and the run
        // count stays clear, so a later fetch still waits the full 4 grants.
        bus.fetch_req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("idle_dbg_ready", 32'(bus.dbg_req_ready), 32'd1);
            tick();
        end
        bus.fetch_req_valid = 1'b1;
        pat = 10'b00000_10000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rearb_fetch_ready", 32'(bus.fetch_req_ready), 32'(pat[i]));
            tick();
        end
        bus.fetch_req_valid = 1'b0;

        // Address window handling.
        bus.dbg_req_write = 1'b1;
        bus.dbg_req_addr  = 32'h00FF_FFFC;
        bus.dbg_req_wdata = 32'h1234_5678;
`ifdef IMEM_ARB_RANGE_CHECK_EN
        #1;
        chk("rc_ready", 32'(bus.dbg_req_ready), 32'd1);
        chk("rc_we",    32'(bus.mem_read_write), 32'd0);
        tick();
        chk("rc_w_err",  32'(bus.dbg_rsp_err), 32'd1);
        chk("rc_w_data", bus.dbg_rsp_data, 32'h0);
        bus.dbg_req_write = 1'b0;
        bus.dbg_req_addr  = 32'h0100_0002;
        #1;
        chk("rc_r_we", 32'(bus.mem_read_write), 32'd0);
        tick();
        chk("rc_r_err",  32'(bus.dbg_rsp_err), 32'd1);
        chk("rc_r_data", bus.dbg_rsp_data, 32'h0);
`else
        // Without the check the address wraps to word 0x3FFF.
        #1;
        chk("nc_we", 32'(bus.mem_read_write), 32'd1);
        tick();
        chk("nc_w_err", 32'(bus.dbg_rsp_err), 32'd0);
        bus.dbg_req_write = 1'b0;
        tick();
        chk("nc_r_err",  32'(bus.dbg_rsp_err), 32'd0);
        chk("nc_r_data", bus.dbg_rsp_data, 32'h1234_5678);
`endif
        bus.dbg_req_valid = 1'b0;
        bus.dbg_req_write = 1'b0;

        // Reset while a fetch is being granted: the response is dropped.
        bus.fetch_req_valid = 1'b1;
        bus.fetch_req_addr  = 32'h0100_0008;
        #1;
        chk("mr_ready", 32'(bus.fetch_req_ready), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_ready_async", 32'(bus.fetch_req_ready), 32'd0);
        tick();
        chk("mr_dropped", 32'(bus.fetch_rsp_valid), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        chk("mr_regrant_rsp",  32'(bus.fetch_rsp_valid), 32'd1);
        chk("mr_regrant_data", bus.fetch_rsp_data, 32'hA000_0002);
        // Asynchronous clear of a live response, with no clock edge.
        reset_n = 1'b0;
        #1;
        chk("mr_async_valid", 32'(bus.fetch_rsp_valid), 32'd0);
        chk("mr_async_data",  bus.fetch_rsp_data, 32'h0);
        bus.fetch_req_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        // The memory contents survive the reset.
        bus.dbg_req_valid = 1'b1;
        bus.dbg_req_addr  = 32'h0100_0010;
        tick();
        chk("mr_mem_kept", bus.dbg_rsp_data, 32'hDEAD_BEEF);
        bus.dbg_req_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
